// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Serialises the CPU fetch (IF) and load/store (D) ports onto a
//               single memory handshake. D has priority, and a burst counter
//               bounds how long IF can be held off.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int                CNT_W       = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0]  C_BURST_MAX = CNT_W'(MAX_DATA_BURST);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q,    mem_be_d;
    logic                if_ack_q,    if_ack_d;
    logic                d_ack_q,     d_ack_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;

    logic                w_burst_full;
    logic                w_grant_d;
    logic                w_grant_if;

    // IF only overtakes a pending D once D has used up its burst allowance.
    assign w_burst_full = (burst_cnt_q == C_BURST_MAX);
    assign w_grant_d    = d_req & ~(if_req & w_burst_full);
    assign w_grant_if   = if_req & ~w_grant_d;

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (w_grant_d) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                    state_d     = BUSY_D;
                    if (!if_req) begin
                        burst_cnt_d = '0;
                    end else if (!w_burst_full) begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else if (w_grant_if) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_be_d    = 4'b1111;
                    burst_cnt_d = '0;
                    state_d     = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata;
                    state_d    = RESP;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign d_stall   = d_req & ~d_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam logic [31:0] C_MASK = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        auto_ready = 1'b0;
    logic        mem_ready_man = 1'b0;
    logic [31:0] mem_rdata_man = '0;

    wire [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    wire        if_ack, if_stall, d_ack, d_stall, mem_req, mem_we;
    wire [3:0]  mem_be;

    // Zero-wait memory model in auto mode: read data is derived from the address.
    wire        mem_ready = auto_ready ? mem_req : mem_ready_man;
    wire [31:0] mem_rdata = auto_ready ? (mem_addr ^ C_MASK) : mem_rdata_man;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_mem_req"},   mem_req,   0);
        check_val({tag, "_mem_we"},    mem_we,    0);
        check_val({tag, "_mem_addr"},  mem_addr,  0);
        check_val({tag, "_mem_wdata"}, mem_wdata, 0);
        check_val({tag, "_mem_be"},    mem_be,    0);
        check_val({tag, "_if_ack"},    if_ack,    0);
        check_val({tag, "_d_ack"},     d_ack,     0);
        check_val({tag, "_if_rdata"},  if_rdata,  0);
        check_val({tag, "_d_rdata"},   d_rdata,   0);
    endtask

    // Waits for the next ack (port 1=IF, 0=D, -1=none within budget).
    task automatic wait_ack(input int exp_port, input string tag);
        int port;
        port = -1;
        for (int i = 0; i < 20 && port < 0; i++) begin
            tick();
            check_val({tag, "_dual_ack"}, if_ack & d_ack, 0);
            if (if_ack) port = 1;
            else if (d_ack) port = 0;
        end
        check_val(tag, port, exp_port);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and quiet idle
        repeat (2) tick();
        check_outputs_zero("rst");
        rst = 1'b1;
        repeat (3) begin
            tick();
            check_val("idle_mem_req", mem_req, 0);
        end

        // IF read, zero wait
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        check_val("t2_stall_c0", if_stall, 1);
        tick();
        check_val("t2_mem_req",  mem_req,  1);
        check_val("t2_mem_addr", mem_addr, 32'h100);
        check_val("t2_mem_be",   mem_be,   4'hF);
        check_val("t2_mem_we",   mem_we,   0);
        check_val("t2_stall_c1", if_stall, 1);
        mem_ready_man = 1'b1; mem_rdata_man = 32'h0050_0093;
        tick();
        check_val("t2_if_ack",   if_ack,   1);
        check_val("t2_if_rdata", if_rdata, 32'h0050_0093);
        check_val("t2_stall_c2", if_stall, 0);
        check_val("t2_mem_req2", mem_req,  0);
        check_val("t2_d_ack",    d_ack,    0);
        if_req = 1'b0; mem_ready_man = 1'b0; mem_rdata_man = '0;
        tick();
        check_val("t2_ack_drop", if_ack,   0);
        check_val("t2_hold",     if_rdata, 32'h0050_0093);

        // D store with 3 wait states
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        mem_rdata_man = 32'h1234_5678;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_val("t3_mem_req",   mem_req,   1);
            check_val("t3_mem_we",    mem_we,    1);
            check_val("t3_mem_addr",  mem_addr,  32'h2004);
            check_val("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check_val("t3_mem_be",    mem_be,    4'b0011);
            check_val("t3_d_ack_early", d_ack,   0);
            check_val("t3_d_stall",   d_stall,   1);
            if (c == 4) mem_ready_man = 1'b1;
        end
        tick();
        check_val("t3_d_ack",    d_ack,   1);
        check_val("t3_d_rdata",  d_rdata, 0);
        check_val("t3_mem_req2", mem_req, 0);
        d_req = 1'b0; mem_ready_man = 1'b0;
        tick();
        check_val("t3_ack_drop", d_ack, 0);

        // Contention: D,D,D,D,IF repeating
        auto_ready = 1'b1;
        d_we = 1'b0; d_addr = 32'h2000; if_addr = 32'h104;
        d_req = 1'b1; if_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_ack((k % 5 == 4) ? 1 : 0, "t4_grant");
            if (k == 4) check_val("t4_if_rdata", if_rdata, 32'h104 ^ C_MASK);
        end
        d_req = 1'b0; if_req = 1'b0;
        repeat (2) tick();

        // Six D-only loads, then contention must again allow a full D burst
        d_addr = 32'h400; d_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_ack(0, "t5_load");
            check_val("t5_d_rdata", d_rdata, (32'h400 + 32'(4 * k)) ^ C_MASK);
            d_addr = 32'h400 + 32'(4 * (k + 1));
        end
        if_req = 1'b1; if_addr = 32'h300;
        for (int k = 0; k < 5; k++) begin
            wait_ack((k == 4) ? 1 : 0, "t5_burst");
        end
        check_val("t5_if_rdata", if_rdata, 32'h300 ^ C_MASK);
        d_req = 1'b0; if_addr = 32'h304;
        tick();
        check_val("t5_idle_req", mem_req, 0);
        tick();
        check_val("t5_if_grant", mem_req,  1);
        check_val("t5_if_addr",  mem_addr, 32'h304);
        check_val("t5_if_be",    mem_be,   4'hF);
        check_val("t5_if_we",    mem_we,   0);
        wait_ack(1, "t5_if_ack");
        if_req = 1'b0;
        tick();

        // Spurious mem_ready in IDLE and RESP
        auto_ready = 1'b0; mem_ready_man = 1'b1; mem_rdata_man = 32'hCAFE_F00D;
        repeat (4) begin
            tick();
            check_val("t6_idle_ack", if_ack | d_ack, 0);
            check_val("t6_idle_req", mem_req, 0);
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        wait_ack(0, "t6_load");
        check_val("t6_d_rdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0;
        repeat (3) begin
            tick();
            check_val("t6_resp_ack", if_ack | d_ack, 0);
            check_val("t6_resp_req", mem_req, 0);
        end

        // Asynchronous reset in the middle of a D access
        mem_ready_man = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h600; d_wdata = 32'h1111_2222; d_be = 4'hF;
        tick();
        tick();
        check_val("t1_busy_req", mem_req, 1);
        #3;
        rst = 1'b0;
        #1;
        check_outputs_zero("t1_async");
        d_req = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) begin
            tick();
            check_val("t1_post_req", mem_req, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
